// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter slice.
// Build option: DMEM_ARB_FIXED_PRIO_EN selects fixed priority (port 0 wins ties).
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

package dmem_arbiter_pkg;

  localparam int unsigned DMEM_DEPTH = 65;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way combinational arbiter: round-robin on `last`, or fixed priority to port 0
// when DMEM_ARB_FIXED_PRIO_EN is defined.
module rr_arb2 (
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic winner
);

`ifdef DMEM_ARB_FIXED_PRIO_EN
  logic unused_last;
  assign unused_last = last;

  always_comb begin
    winner = req1 & ~req0;
  end
`else
  always_comb begin
    winner = req1;
    // On a tie the port that did not win last time goes next.
    if (req0 && req1) begin
      winner = ~last;
    end
  end
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Shares a single-port data memory between the LSU (port 0) and a debug/loader port (port 1).
// Build option: DMEM_ARB_FIXED_PRIO_EN (see rr_arb2).
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned DW        = `DATA_WIDTH,
  parameter int unsigned MEM_DEPTH = DMEM_DEPTH
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [DW-1:0] addr0,
  input  logic [DW-1:0] addr1,
  input  logic [DW-1:0] wd0,
  input  logic [DW-1:0] wd1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          done0,
  output logic          done1,
  output logic [DW-1:0] rdata,
  output logic          err,
  output logic [DW-1:0] mem_addr,
  output logic [DW-1:0] mem_wd,
  output logic          mem_we,
  output logic          mem_read,
  input  logic [DW-1:0] mem_rd
);

  state_e        state_q, state_d;
  logic          last_q;
  logic          win_q;
  logic          we_q;
  logic [DW-1:0] addr_q;
  logic [DW-1:0] wd_q;
  logic [DW-1:0] rdata_q;
  logic          gnt0_q, gnt1_q;
  logic          done0_q, done1_q;
  logic          err_q;
  logic          winner;
  logic          any_req;
  logic          addr_ok;

  rr_arb2 u_arb (
    .req0   (req0),
    .req1   (req1),
    .last   (last_q),
    .winner (winner)
  );

  assign any_req = req0 | req1;
  assign addr_ok = addr_q < DW'(MEM_DEPTH);

  always_comb begin
    state_d  = state_q;
    mem_we   = 1'b0;
    mem_read = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        state_d  = ST_RESP;
        // Gated with rst so a write caught by reset never reaches the array.
        mem_we   = addr_ok & we_q & ~rst;
        mem_read = addr_ok & ~we_q;
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      last_q  <= 1'b1;
      win_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wd_q    <= '0;
      rdata_q <= '0;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      err_q   <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (any_req) begin
            win_q  <= winner;
            last_q <= winner;
            we_q   <= winner ? we1 : we0;
            addr_q <= winner ? addr1 : addr0;
            wd_q   <= winner ? wd1 : wd0;
            gnt0_q <= ~winner;
            gnt1_q <= winner;
          end
        end
        ST_ACCESS: begin
          done0_q <= ~win_q;
          done1_q <= win_q;
          err_q   <= ~addr_ok;
          if (!addr_ok) begin
            rdata_q <= '0;
          end else if (!we_q) begin
            rdata_q <= mem_rd;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign gnt0     = gnt0_q;
  assign gnt1     = gnt1_q;
  assign done0    = done0_q;
  assign done1    = done1_q;
  assign err      = err_q;
  assign rdata    = rdata_q;
  assign mem_addr = addr_q;
  assign mem_wd   = wd_q;

endmodule
